// File: rtl/handshake_rx.sv
// handshake_rx: receive side of the core-to-core req/ack link.
// Captures a partner psum row on req, returns a one-cycle ack plus a pop
// to the sender's FIFO, and buffers rows in a local show-ahead FIFO.
// Optional: define HANDSHAKE_RX_XCNT_EN to add o_xfer_cnt, a 16-bit
// wrapping count of captured rows.
module handshake_rx #(
  parameter  int BW    = 16,
  parameter  int COL   = 8,
  parameter  int DEPTH = 8,
  localparam int W     = COL * BW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [W-1:0]  in_data,
  output logic          ack,
  output logic          o_src_rd,
  input  logic          rd,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
`ifdef HANDSHAKE_RX_XCNT_EN
  ,
  output logic [15:0]   o_xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [W-1:0]    r_mem [DEPTH];
  logic            w_wr;
  logic            w_rd;

  // Capture only from IDLE, and only with room judged on pre-edge occupancy,
  // so a same-cycle rd never makes room for a write.
  assign w_wr = (r_state == IDLE) && req && !o_full;
  assign w_rd = rd && !o_empty;

  // State register; async reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: ACK lasts one cycle, WAIT_LOW holds off a req still high.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:     w_next = w_wr ? ACK : IDLE;
      ACK:      w_next = WAIT_LOW;
      WAIT_LOW: w_next = req ? WAIT_LOW : IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // ack and the sender pop come straight off the state register.
  assign ack      = (r_state == ACK);
  assign o_src_rd = (r_state == ACK);

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Row storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);

`ifdef HANDSHAKE_RX_XCNT_EN
  logic [15:0] r_xfer_cnt;

  // Free-running capture count, wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_xfer_cnt <= '0;
    else if (w_wr) r_xfer_cnt <= r_xfer_cnt + 16'd1;
  end

  assign o_xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: doc/handshake_rx.md
Name: handshake_rx

Overview:
- Receive-side partner of the core-to-core request/ack sender that sits after each core's sfp_row output FIFO.
- Watches the incoming req, captures the partner core's psum row from the data bus, and returns a one-cycle ack.
- Pulses a pop to the sender's FIFO for each captured row and buffers the rows in a local show-ahead FIFO that the local accumulator drains.

Parameters:
- BW, 16, bits per psum lane.
- COL, 8, lanes per row; row width W = COL*BW.
- DEPTH, 8, local FIFO entries (power of 2, >= 2); AW = log2(DEPTH).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request from the partner core's sender; row on in_data is valid while req is high.
- in_data  input  W  partner psum row.
- ack  output  1  one-cycle acknowledge to the sender (registered).
- o_src_rd  output  1  one-cycle pop to the sender's sfp_row FIFO; coincident with ack.
- rd  input  1  local consumer pop.
- o_data  output  W  head of local FIFO (show-ahead).
- o_empty  output  1  local FIFO empty.
- o_full  output  1  local FIFO full.
- o_count  output  AW+1  occupancy, 0..DEPTH.

Behaviour:
- Reset (async, active-high, any time including mid-transfer):
  - state=IDLE; ack=0, o_src_rd=0.
  - Pointers and count = 0; o_empty=1, o_full=0.
  - FIFO contents discarded; o_data is don't-care while empty.
- FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE: if req=1 and o_full=0 at the edge, write in_data at wr_ptr, wr_ptr+1 (wraps mod DEPTH), go to ACK. Otherwise stay in IDLE.
  - ACK: ack=1 and o_src_rd=1 for exactly this cycle; always go to WAIT_LOW. No capture in this state.
  - WAIT_LOW: ack=0; go to IDLE when req=0, else stay. This prevents recapturing a req that is still high.
- ack and o_src_rd are decoded from registered state: ack = o_src_rd = (state==ACK).
- Latency:
  - req sampled high at edge k -> ack high in cycle k+1, and the row is visible on o_data in cycle k+1 if the FIFO was empty.
  - With the standard sender (req drops two cycles after capture) a full transfer is 3 cycles, IDLE to IDLE.
- Full: while o_full=1 in IDLE, req is held off with no ack and no pop. Full is evaluated on pre-edge occupancy, so a rd in the same cycle does not permit a write that cycle.
- Local FIFO:
  - rd=1 with o_empty=0 advances rd_ptr (wraps). rd when empty is ignored.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - o_data = mem[rd_ptr] combinationally.
- Counting: o_count = writes - reads. o_full = (o_count==DEPTH); o_empty = (o_count==0).
- req dropping while in ACK: the row is already captured; FSM proceeds ACK -> WAIT_LOW -> IDLE normally.
- Unknown state encoding recovers to IDLE on the next edge.

Optional Feature:
- Macro: HANDSHAKE_RX_XCNT_EN.
- Defined: adds output o_xfer_cnt [15:0].
  - Increments on every capture; wraps 0xFFFF -> 0.
  - Cleared by reset.
  - Readable at any time.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-ACK: reset asserted while state=ACK -> ack=0 immediately (asynchronous), o_empty=1, o_count=0; first post-reset req=1 is captured normally.
- Single transfer: req=1 with in_data=0x0001_0002_..._0008, dropping two cycles after capture -> ack and o_src_rd high for exactly 1 cycle, o_data matches the row, o_count=1, FSM back in IDLE 3 cycles after capture.
- Stuck req: hold req=1 for 10 cycles -> exactly one capture, one ack pulse, o_count=1.
- Full back-pressure: 8 back-to-back transfers with rd=0 -> o_full=1; 9th req gets no ack. Pulse rd once -> o_count=7, then the 9th row is captured and acked.
- Wrap and concurrency: 20 transfers with rd=1 every cycle that o_empty=0 -> rows read out in order with no loss or duplication; no ack is issued while full. A cycle with simultaneous write and rd leaves o_count unchanged. rd while empty leaves o_count=0.
- HANDSHAKE_RX_XCNT_EN: 5 transfers -> o_xfer_cnt=5. Force the counter to 0xFFFF, then 1 transfer -> 0x0000.
